// File: rtl/qr_pkg.sv
// Shared constants and state encoding for the systolic QR array cells.
package qr_pkg;

    localparam int unsigned BIT_SIZE    = 26;
    localparam int unsigned SHIFT_VALID = 4;
    localparam int unsigned ITER        = 12;
    localparam int unsigned DATA_W      = 13;
    localparam int unsigned K_W         = 9;
    localparam int unsigned PROD_W      = BIT_SIZE + K_W;

    // CORDIC gain 0.6055 in Q8
    localparam logic signed [K_W-1:0] K = 9'sd155;

    typedef enum logic [1:0] {IDLE, ACC, FLUSH} state_e;

    // (v * K) >>> 8, wrapped back to the datapath width
    function automatic logic signed [BIT_SIZE-1:0] scale_k(input logic signed [BIT_SIZE-1:0] v);
        return BIT_SIZE'(($signed({{K_W{v[BIT_SIZE-1]}}, v}) *
                          $signed({{BIT_SIZE{K[K_W-1]}}, K})) >>> 8);
    endfunction

endpackage

// File: rtl/cordic_rot12.sv
// Combinational rotation-mode CORDIC chain: ITER micro-rotations steered by di.
module cordic_rot12
    import qr_pkg::*;
(
    input  logic signed [BIT_SIZE-1:0] x,
    input  logic signed [BIT_SIZE-1:0] y,
    input  logic        [ITER-1:0]     di,
    output logic signed [BIT_SIZE-1:0] x12,
    output logic signed [BIT_SIZE-1:0] y12
);

    logic signed [BIT_SIZE-1:0] xc;
    logic signed [BIT_SIZE-1:0] yc;
    logic signed [BIT_SIZE-1:0] xs;
    logic signed [BIT_SIZE-1:0] ys;
    logic        [ITER-1:0]     dsh;

    always_comb begin
        xc  = x;
        yc  = y;
        xs  = '0;
        ys  = '0;
        dsh = di;
        // Both updates use the pre-iteration x and y
        for (int i = 0; i < ITER; i++) begin
            xs = xc >>> i;
            ys = yc >>> i;
            if (dsh[0]) begin
                xc = xc - ys;
                yc = yc + xs;
            end else begin
                xc = xc + ys;
                yc = yc - xs;
            end
            dsh = dsh >> 1;
        end
        x12 = xc;
        y12 = yc;
    end

endmodule

// File: rtl/givens_rotate.sv
// Givens-rotation cell: rotates each row element against the stored R element,
// emits the residual, flushes R at end of column and forwards directions right.
module givens_rotate
    import qr_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic        [ITER-1:0]   di_in,
    input  logic                     first,
    input  logic                     last_in,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     last_out,
    output logic        [ITER-1:0]   di_out,
    output logic                     di_valid_out,
    output logic                     first_out,
    output logic                     last_fwd,
    output logic                     overrun_err
);

    // Stage A
    logic                       a_valid_q, a_valid_d;
    logic signed [BIT_SIZE-1:0] xa_q, xa_d;
    logic        [ITER-1:0]     a_di_q, a_di_d;
    logic                       a_first_q, a_first_d;
    logic                       a_last_q, a_last_d;

    // Column state and result registers
    state_e                     state_q, state_d;
    logic signed [BIT_SIZE-1:0] r_q, r_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]   data_out_q, data_out_d;
    logic                       last_out_q, last_out_d;
    logic                       err_q, err_d;

    // Forward path
    logic [ITER-1:0] di_out_q, di_out_d;
    logic            di_valid_q, di_valid_d;
    logic            first_out_q, first_out_d;
    logic            last_fwd_q, last_fwd_d;

    logic signed [BIT_SIZE-1:0] x12;
    logic signed [BIT_SIZE-1:0] y12;
    logic signed [BIT_SIZE-1:0] r_rot;
    logic signed [BIT_SIZE-1:0] y_scaled;
    logic signed [DATA_W-1:0]   rot_data;
    logic signed [DATA_W-1:0]   flush_data;

    cordic_rot12 u_rot (
        .x   (xa_q),
        .y   (r_q),
        .di  (a_di_q),
        .x12 (x12),
        .y12 (y12)
    );

    assign r_rot      = scale_k(x12);
    assign y_scaled   = scale_k(y12);
    assign rot_data   = DATA_W'(y_scaled >>> SHIFT_VALID);
    assign flush_data = DATA_W'(r_q >>> SHIFT_VALID);

    always_comb begin
        a_valid_d = in_valid;
        xa_d      = xa_q;
        a_di_d    = a_di_q;
        a_first_d = a_first_q;
        a_last_d  = a_last_q;
        if (in_valid) begin
            xa_d      = {{(BIT_SIZE - DATA_W - SHIFT_VALID){data_in[DATA_W-1]}}, data_in,
                         {SHIFT_VALID{1'b0}}};
            a_di_d    = di_in;
            a_first_d = first;
            a_last_d  = last_in;
        end

        di_out_d    = di_in;
        di_valid_d  = in_valid;
        first_out_d = first;
        last_fwd_d  = last_in;
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        out_valid_d = 1'b0;
        last_out_d  = 1'b0;
        data_out_d  = data_out_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (a_valid_q) begin
                    if (a_first_q) begin
                        r_d     = xa_q;
                        state_d = a_last_q ? FLUSH : ACC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ACC: begin
                if (a_valid_q) begin
                    if (a_first_q) begin
                        // Restart: the old partial R is abandoned without a flush
                        err_d   = 1'b1;
                        r_d     = xa_q;
                        state_d = a_last_q ? FLUSH : ACC;
                    end else begin
                        r_d         = r_rot;
                        data_out_d  = rot_data;
                        out_valid_d = 1'b1;
                        if (a_last_q) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                out_valid_d = 1'b1;
                last_out_d  = 1'b1;
                data_out_d  = flush_data;
                r_d         = '0;
                state_d     = IDLE;
                if (a_valid_q) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_valid_q   <= 1'b0;
            xa_q        <= '0;
            a_di_q      <= '0;
            a_first_q   <= 1'b0;
            a_last_q    <= 1'b0;
            state_q     <= IDLE;
            r_q         <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            last_out_q  <= 1'b0;
            err_q       <= 1'b0;
            di_out_q    <= '0;
            di_valid_q  <= 1'b0;
            first_out_q <= 1'b0;
            last_fwd_q  <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            xa_q        <= xa_d;
            a_di_q      <= a_di_d;
            a_first_q   <= a_first_d;
            a_last_q    <= a_last_d;
            state_q     <= state_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            last_out_q  <= last_out_d;
            err_q       <= err_d;
            di_out_q    <= di_out_d;
            di_valid_q  <= di_valid_d;
            first_out_q <= first_out_d;
            last_fwd_q  <= last_fwd_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign data_out     = data_out_q;
    assign last_out     = last_out_q;
    assign overrun_err  = err_q;
    assign di_out       = di_out_q;
    assign di_valid_out = di_valid_q;
    assign first_out    = first_out_q;
    assign last_fwd     = last_fwd_q;

endmodule

// File: tb/tb_givens_rotate.sv
// Scoreboard bench for givens_rotate: stimulus pushes expected outputs, a monitor pops them.
module tb_givens_rotate;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [12:0] data_in = '0;
    logic        [11:0] di_in = '0;
    logic               first = 1'b0;
    logic               last_in = 1'b0;
    logic               out_valid;
    logic signed [12:0] data_out;
    logic               last_out;
    logic        [11:0] di_out;
    logic               di_valid_out;
    logic               first_out;
    logic               last_fwd;
    logic               overrun_err;

    givens_rotate dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .di_in        (di_in),
        .first        (first),
        .last_in      (last_in),
        .out_valid    (out_valid),
        .data_out     (data_out),
        .last_out     (last_out),
        .di_out       (di_out),
        .di_valid_out (di_valid_out),
        .first_out    (first_out),
        .last_fwd     (last_fwd),
        .overrun_err  (overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] data;
        logic        last;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    longint m_r = 0;

    function automatic longint w26(longint v);
        longint m;
        m = v & ((longint'(1) << 26) - 1);
        if (m >= (longint'(1) << 25)) m = m - (longint'(1) << 26);
        return m;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(longint v, logic l);
        exp_t e;
        e.data = 13'(v);
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic send(int d, logic [11:0] di, logic f, logic l);
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 13'(d);
        di_in    = di;
        first    = f;
        last_in  = l;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            data_in  = '0;
            di_in    = '0;
            first    = 1'b0;
            last_in  = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle(1);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_r = 0;
    endtask

    // Drives one sample of a legal column and pushes what the cell must emit for it
    task automatic model_send(int d, logic [11:0] di, logic f, logic l);
        longint xa, x, y, sx, sy;
        send(d, di, f, l);
        xa = longint'(d) * 16;
        if (f) begin
            m_r = xa;
        end else begin
            x = xa;
            y = m_r;
            for (int i = 0; i < 12; i++) begin
                sx = x >>> i;
                sy = y >>> i;
                if (di[i]) begin
                    x = w26(x - sy);
                    y = w26(y + sx);
                end else begin
                    x = w26(x + sy);
                    y = w26(y - sx);
                end
            end
            push(((y * 155) >>> 8) >>> 4, 1'b0);
            m_r = w26((x * 155) >>> 8);
        end
        if (l) begin
            push(m_r >>> 4, 1'b1);
            m_r = 0;
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_data_out"}, longint'(data_out), 0);
        chk({tag, "_last_out"}, longint'(last_out), 0);
        chk({tag, "_di_out"}, longint'(di_out), 0);
        chk({tag, "_di_valid_out"}, longint'(di_valid_out), 0);
        chk({tag, "_first_out"}, longint'(first_out), 0);
        chk({tag, "_last_fwd"}, longint'(last_fwd), 0);
        chk({tag, "_overrun_err"}, longint'(overrun_err), 0);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data %0d last %0b, expected no output",
                         data_out, last_out);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", longint'(data_out), longint'($signed(e.data)));
                chk("sb_last", longint'(last_out), longint'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int len, pick, d;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        // Single-element column: load then flush, no result slot output
        send(37, 12'h000, 1'b1, 1'b1);
        push(37, 1'b1);
        idle(2);
        chk("single_no_result", longint'(out_valid), 0);
        idle(1);
        chk("single_flush_valid", longint'(out_valid), 1);
        chk("single_flush_last", longint'(last_out), 1);
        idle(1);
        chk("single_back_idle", longint'(out_valid), 0);

        // Zero rotation
        send(0, 12'h000, 1'b1, 1'b0);
        send(0, 12'hFFF, 1'b0, 1'b1);
        push(0, 1'b0);
        push(0, 1'b1);
        idle(2);

        // Hand-worked rotation: R = 100<<4, x = 0, all di set
        send(100, 12'h000, 1'b1, 1'b0);
        send(0, 12'hFFF, 1'b0, 1'b1);
        push(-18, 1'b0);
        push(-99, 1'b1);
        idle(2);

        // Forward path
        send(0, 12'hA5A, 1'b1, 1'b1);
        push(0, 1'b1);
        idle(1);
        chk("fwd_di_out", longint'(di_out), 'hA5A);
        chk("fwd_di_valid", longint'(di_valid_out), 1);
        chk("fwd_first_out", longint'(first_out), 1);
        chk("fwd_last_fwd", longint'(last_fwd), 1);
        idle(1);
        chk("fwd_di_valid_clr", longint'(di_valid_out), 0);
        chk("fwd_di_out_clr", longint'(di_out), 0);
        chk("fwd_first_clr", longint'(first_out), 0);
        idle(2);

        // Random columns with extremes, back-to-back within each column
        m_r = 0;
        for (int c = 0; c < 16; c++) begin
            len = $urandom_range(2, 12);
            for (int e = 0; e < len; e++) begin
                pick = $urandom_range(0, 5);
                if (pick == 0) d = 4095;
                else if (pick == 1) d = -4095;
                else d = int'($urandom_range(0, 8190)) - 4095;
                model_send(d, 12'($urandom), e == 0, e == len - 1);
            end
            idle(1);
        end
        idle(3);
        chk("legal_no_err", longint'(overrun_err), 0);

        // Non-first sample while idle
        send(9, 12'h000, 1'b0, 1'b0);
        idle(3);
        chk("idle_drop_err", longint'(overrun_err), 1);
        do_reset();
        chk("err_cleared", longint'(overrun_err), 0);

        // Sample during the flush cycle is dropped
        send(200, 12'h000, 1'b1, 1'b1);
        push(200, 1'b1);
        send(7, 12'hFFF, 1'b0, 1'b0);
        idle(3);
        chk("flush_drop_err", longint'(overrun_err), 1);
        do_reset();

        // first while accumulating restarts the column
        send(50, 12'h000, 1'b1, 1'b0);
        send(60, 12'h000, 1'b1, 1'b1);
        push(60, 1'b1);
        idle(3);
        chk("restart_err", longint'(overrun_err), 1);

        // Reset after 3 of 6 elements
        m_r = 0;
        model_send(10, 12'h000, 1'b1, 1'b0);
        model_send(20, 12'h3C5, 1'b0, 1'b0);
        send(30, 12'h0F0, 1'b0, 1'b0);
        idle(1);
        #2 reset = 1'b0;
        #1 chk_all_zero("midreset");
        m_r = 0;
        @(negedge clk);
        reset = 1'b1;
        send(-5, 12'h000, 1'b1, 1'b1);
        push(-5, 1'b1);
        idle(4);

        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain_pending", longint'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/givens_rotate.md
# givens_rotate

Givens-rotation cell of the systolic QR array, directly downstream (to the right) of the Givens-generation cell. It receives the 12 CORDIC micro-rotation directions produced by the generation cell for each incoming row element. It rotates the incoming element against its locally stored R element and passes the rotated residual downward. At end of column it flushes the final R element, and it forwards directions and flags to its right neighbour one cycle later.

## Interface
- BIT_SIZE, 26: internal signed datapath width.
- SHIFT_VALID, 4: fractional bits added on entry (`data_in <<< 4`).
- ITER, 12: micro-rotation count; equals the `di` width.
- K, 155: CORDIC gain constant, 9-bit signed (0.6055 × 256), applied as `(v*K) >>> 8`.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  sample present this cycle.
- data_in  in  13  signed row element.
- di_in  in  12  directions; bit i applies to iteration i.
- first  in  1  sample is the first element of a column (load, no rotation).
- last_in  in  1  sample is the final element of a column.
- out_valid  out  1  `data_out` valid.
- data_out  out  13  signed rotated element or flushed R element.
- last_out  out  1  marks the flushed R element.
- di_out, di_valid_out, first_out, last_fwd  out  12/1/1/1  registered forward of `di_in`, `in_valid`, `first`, `last_in`.
- overrun_err  out  1  sticky protocol-error flag.

## Operation
- **Stage A:** on an edge with `in_valid`, register:
  - `xa = data_in <<< 4`, sign-extended to 26 bits,
  - `di`, `first`, `last`.
- **Stage B (combinational, from `xa`):**
  - Start values: `x0 = xa`, `y0 = r_reg`.
  - For i = 0..11, compute from pre-iteration values:
    - `di[i] = 1`: `x -= y>>>i`, `y += x>>>i`.
    - `di[i] = 0`: `x += y>>>i`, `y -= x>>>i`.
  - All arithmetic is 26-bit two's-complement wrap.
- **Update at the next edge:**
  - Non-first sample: `r_reg <= (x12*K) >>> 8` truncated to 26 bits; `data_out <= ((y12*K) >>> 8) >>> 4`, low 13 bits, no saturation; `out_valid = 1`, `last_out = 0`.
  - First sample: `r_reg <= xa`; no output.
- **Flush:** the cycle after a last sample's result slot emits `data_out = r_reg >>> 4` with `out_valid = 1`, `last_out = 1`. After the flush, `r_reg` clears to 0.
- **FSM:**
  - IDLE → ACC on a first sample.
  - ACC → FLUSH on a last sample (including first&last from IDLE).
  - FLUSH → IDLE after the flush cycle.
- **Protocol errors** (each sets `overrun_err`, which holds until reset):
  - Non-first sample in IDLE: dropped.
  - Sample arriving in the flush cycle: dropped.
  - `first` in ACC: restarts the column; old `r_reg` is discarded, not flushed.

## Timing
- Sample accepted at edge n → rotation result registered at edge n+1, visible in cycle n+1.
- Flush registered at edge n+2.
- Back-to-back samples are supported: `r_reg` updates at edge n+1, before sample n+1 is evaluated.
- Forward outputs equal the inputs delayed by exactly one edge; they are not gated by the FSM.
- Reset values (asynchronous): all outputs 0, `r_reg` 0, stage-A registers 0, FSM IDLE, `overrun_err` 0.
- Reset mid-column: the partial R element is lost; the next column must start with `first`.

## Structure
- Shared package `qr_pkg`: `BIT_SIZE`, `SHIFT_VALID`, `ITER`, `K`, and the FSM state enum `{IDLE, ACC, FLUSH}`; the generation cell uses the same constants.
- Sub-module `cordic_rot12`: purely combinational 12-iteration micro-rotation chain. Inputs are x, y, di; outputs are x12, y12. It is reused by any future rotation-mode cell.

## Test plan
- **Single-element column:** `first`=`last_in`=1, `data_in`=37 → no output in cycle n+1; `data_out`=37 with `out_valid`=`last_out`=1 at edge n+2; state returns to IDLE.
- **Zero rotation:** first `data_in`=0, then `data_in`=0 with `di`=0xFFF, `last_in`=1 → `data_out`=0 with `last_out`=0, then flush `data_out`=0 with `last_out`=1.
- **Random columns of 2–12 elements, back-to-back, random `di`:** every `data_out` and flush matches the bit-accurate model, including ±4095 extremes with wrap.
- **Forward path:** `di_in`=0xA5A and `in_valid` at edge n → `di_out`=0xA5A and `di_valid_out`=1 after edge n; cleared after edge n+1 if there is no new sample.
- **Protocol errors:**
  - Non-first sample in IDLE → no output, `overrun_err`=1.
  - Sample during the flush cycle → dropped, flush value still correct.
  - `first` in ACC → restart, no flush of the old value.
- **Reset mid-column:** assert `reset` after 3 of 6 elements → all outputs 0 immediately; a fresh single-element column with `data_in`=-5 then flushes -5.
